input_tile_read_scheduler: RTL and testbench
============================================

Name: input_tile_read_scheduler

Overview:
- Sequences the on-chip input-buffer read master for one tile of an input feature map.
- Walks a rows x cols window at base + r*row_stride + c and issues one read request per cycle.
- Bounds in-flight requests with an outstanding-read credit counter and counts returned data.
- Forwards returned words to the PE array with a last-word marker and signals tile completion to the layer controller.

Parameters:
ADDR_W, 11, word address width of the input buffer
DATA_W, 16, data word width
DIM_W, 6, width of the tile_rows / tile_cols fields
MAX_OUTST, 4, maximum reads in flight (must be >= 1 and < 16)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse that launches a tile
abort  in  1  level; stops issuing new reads
base_addr  in  ADDR_W  address of tile element (0,0)
row_stride  in  ADDR_W  address step between tile rows
tile_rows  in  DIM_W  number of rows; 0 means empty tile
tile_cols  in  DIM_W  number of columns; 0 means empty tile
addr_read_input  out  ADDR_W  request address to the read master
read_en_input  out  1  request strobe; one read per high cycle
data_valid  in  1  returned-word strobe from the read master
data_read  in  DATA_W  returned word
pe_data  out  DATA_W  word forwarded to the PE array
pe_valid  out  1  pe_data qualifier
pe_last  out  1  high with the final word of the tile
busy  out  1  high from start acceptance until done
done  out  1  one-cycle completion pulse
aborted  out  1  high with done when the tile ended by abort

Behaviour:
- Clock and reset:
  - Single clock; clk is the only clock.
  - rst_n is asynchronous and active-low; assertion takes effect immediately, even mid-tile.
  - All outputs, counters and FSM state reset to 0 / IDLE.
  - No reads are issued for at least one cycle after rst_n deasserts.
- FSM states: IDLE, ISSUE, DRAIN, FINISH.
- IDLE:
  - On start, latch base_addr, row_stride, tile_rows and tile_cols, and set busy.
  - If tile_rows==0 or tile_cols==0, go to FINISH. No read is issued.
  - Otherwise go to ISSUE with r=0, c=0, row_base=base_addr and cur_addr=base_addr.
  - start is ignored outside IDLE.
- ISSUE:
  - Each cycle with outst < MAX_OUTST and abort==0, drive read_en_input=1 and addr_read_input=cur_addr, both registered.
  - Then advance the walk:
    - If c < cols-1: c+1 and cur_addr+1.
    - Otherwise: c=0, r+1, row_base += row_stride, and cur_addr = the new row_base.
  - All address arithmetic is modulo 2^ADDR_W, so wrap-around is silent. No multiplier is used.
  - After issuing element (rows-1, cols-1), go to DRAIN.
  - If abort==1, go to DRAIN without issuing; set the aborted flag.
  - read_en_input is 0 in every cycle where no request is issued.
- Credit counter (outst):
  - Increments on an issue and decrements on data_valid.
  - On an issue and data_valid in the same cycle, outst is unchanged.
  - Issue is blocked at MAX_OUTST, which gives back-to-back reads with at most MAX_OUTST in flight.
- Returns:
  - Each data_valid while busy produces pe_data <= data_read and pe_valid=1 on the next cycle. Latency is 1 cycle.
  - ret_cnt increments on each return.
  - pe_last=1 with the return where ret_cnt == rows*cols-1. The product is computed at start into a 2*DIM_W register.
- DRAIN:
  - Wait until outst==0, counting the same cycle's decrement, then go to FINISH.
  - Abort during DRAIN has no further effect. In-flight returns are still forwarded.
  - After abort, pe_last is asserted only if the final element was reached.
- FINISH:
  - Pulse done=1 for one cycle; aborted equals the latched flag in that cycle.
  - Clear busy and return to IDLE.
  - Total latency from start to done for an empty tile is 2 cycles.
- Stray returns: data_valid while not busy is ignored. It produces no pe_valid and does not underflow outst, which saturates at 0.
- Cross-cycle idle: in all states other than ISSUE, read_en_input=0 and addr_read_input holds its last value.

Test Plan:
- base=0x010, stride=32, 2x3 tile, data returned 2 cycles after each request -> addresses 0x010, 0x011, 0x012, 0x030, 0x031, 0x032 in order; 6 pe_valid; pe_last on the 6th; done 1 cycle after the 6th return; aborted=0.
- MAX_OUTST=4, 1x8 tile, read master withholds data_valid for 10 cycles -> exactly 4 reads issued, then read_en_input=0 until returns arrive; outst never exceeds 4; all 8 words delivered.
- base=0x7FE, stride=0x002, 2x3 tile -> addresses 0x7FE, 0x7FF, 0x000, 0x000, 0x001, 0x002 (modulo-2^11 wrap).
- tile_rows=0 -> no read_en_input; busy high 1 cycle; done pulses 2 cycles after start; no pe_valid.
- 4x4 tile, abort raised after the 5th issue with 3 reads outstanding -> no further reads; 3 more pe_valid; done with aborted=1; pe_last never asserted.
- rst_n pulled low mid-ISSUE with 2 reads outstanding -> outputs 0 immediately (asynchronous); late data_valid after reset produces no pe_valid; a fresh start then runs the tile normally.

Source files
------------

// File: rtl/input_tile_read_scheduler.sv
// Input-buffer read sequencer for one feature-map tile: walks the tile window,
// meters reads with an outstanding-credit counter and forwards returns to the PEs.
module input_tile_read_scheduler #(
    parameter int ADDR_W    = 11,
    parameter int DATA_W    = 16,
    parameter int DIM_W     = 6,
    parameter int MAX_OUTST = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] row_stride,
    input  logic [DIM_W-1:0]  tile_rows,
    input  logic [DIM_W-1:0]  tile_cols,
    output logic [ADDR_W-1:0] addr_read_input,
    output logic              read_en_input,
    input  logic              data_valid,
    input  logic [DATA_W-1:0] data_read,
    output logic [DATA_W-1:0] pe_data,
    output logic              pe_valid,
    output logic              pe_last,
    output logic              busy,
    output logic              done,
    output logic              aborted
);

    localparam int OW = $clog2(MAX_OUTST + 1);
    localparam int PW = 2 * DIM_W;
    localparam logic [OW-1:0] MAX_O = OW'(MAX_OUTST);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_FINISH
    } state_t;

    state_t state, state_nxt;

    logic [DIM_W-1:0]  rows_q;
    logic [DIM_W-1:0]  cols_q;
    logic [ADDR_W-1:0] stride_q;
    logic [DIM_W-1:0]  r_q;
    logic [DIM_W-1:0]  c_q;
    logic [ADDR_W-1:0] row_base_q;
    logic [ADDR_W-1:0] cur_addr_q;
    logic [PW-1:0]     total_q;
    logic [PW-1:0]     ret_cnt_q;
    logic [OW-1:0]     outst_q;
    logic              abort_flag_q;

    logic              issue;
    logic              ret;
    logic              dec;
    logic              last_elem;
    logic              last_col;
    logic              empty_tile;
    logic              launch;
    logic [OW-1:0]     outst_nxt;
    logic [ADDR_W-1:0] next_row_base;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = empty_tile ? S_FINISH : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (abort) begin
                    state_nxt = S_DRAIN;
                end else if (issue && last_elem) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (outst_nxt == '0) begin
                    state_nxt = S_FINISH;
                end
            end
            S_FINISH: begin
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        last_col      = (c_q == cols_q - DIM_W'(1));
        last_elem     = last_col && (r_q == rows_q - DIM_W'(1));
        empty_tile    = (tile_rows == '0) || (tile_cols == '0);
        launch        = (state == S_IDLE) && start;
        issue         = (state == S_ISSUE) && !abort && (outst_q < MAX_O);
        ret           = data_valid && busy;
        // Saturating credit: a stray return can never wrap the counter.
        dec           = data_valid && (outst_q != '0);
        next_row_base = row_base_q + stride_q;
        outst_nxt     = outst_q;
        if (issue && !dec) begin
            outst_nxt = outst_q + OW'(1);
        end else if (!issue && dec) begin
            outst_nxt = outst_q - OW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rows_q          <= '0;
            cols_q          <= '0;
            stride_q        <= '0;
            r_q             <= '0;
            c_q             <= '0;
            row_base_q      <= '0;
            cur_addr_q      <= '0;
            total_q         <= '0;
            ret_cnt_q       <= '0;
            outst_q         <= '0;
            abort_flag_q    <= 1'b0;
            addr_read_input <= '0;
            read_en_input   <= 1'b0;
            pe_data         <= '0;
            pe_valid        <= 1'b0;
            pe_last         <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            aborted         <= 1'b0;
        end else begin
            read_en_input <= issue;
            outst_q       <= outst_nxt;
            done          <= (state == S_FINISH);
            aborted       <= (state == S_FINISH) && abort_flag_q;
            pe_valid      <= ret;
            pe_last       <= ret && (ret_cnt_q == total_q - PW'(1));

            if (ret) begin
                pe_data   <= data_read;
                ret_cnt_q <= ret_cnt_q + PW'(1);
            end

            if (launch) begin
                rows_q       <= tile_rows;
                cols_q       <= tile_cols;
                stride_q     <= row_stride;
                r_q          <= '0;
                c_q          <= '0;
                row_base_q   <= base_addr;
                cur_addr_q   <= base_addr;
                total_q      <= PW'(tile_rows) * PW'(tile_cols);
                ret_cnt_q    <= '0;
                abort_flag_q <= 1'b0;
                busy         <= 1'b1;
            end

            if ((state == S_ISSUE) && abort) begin
                abort_flag_q <= 1'b1;
            end

            // Row stepping by accumulation keeps the address path adder-only.
            if (issue) begin
                addr_read_input <= cur_addr_q;
                if (!last_col) begin
                    c_q        <= c_q + DIM_W'(1);
                    cur_addr_q <= cur_addr_q + ADDR_W'(1);
                end else begin
                    c_q        <= '0;
                    r_q        <= r_q + DIM_W'(1);
                    row_base_q <= next_row_base;
                    cur_addr_q <= next_row_base;
                end
            end

            if (state == S_FINISH) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_input_tile_read_scheduler.sv
// Bench for input_tile_read_scheduler: vector table, hand-built reset/stray
// sequences and randomized tiles against a count-based reference model.
module tb_input_tile_read_scheduler;

    localparam int MAX = 4;
    localparam int P_IDLE = 0;
    localparam int P_ISS  = 1;
    localparam int P_DRN  = 2;
    localparam int P_FIN  = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [10:0] base_addr;
    logic [10:0] row_stride;
    logic [5:0]  tile_rows;
    logic [5:0]  tile_cols;
    logic [10:0] addr_read_input;
    logic        read_en_input;
    logic        data_valid;
    logic [15:0] data_read;
    logic [15:0] pe_data;
    logic        pe_valid;
    logic        pe_last;
    logic        busy;
    logic        done;
    logic        aborted;

    input_tile_read_scheduler #(
        .ADDR_W(11),
        .DATA_W(16),
        .DIM_W(6),
        .MAX_OUTST(MAX)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .abort(abort),
        .base_addr(base_addr),
        .row_stride(row_stride),
        .tile_rows(tile_rows),
        .tile_cols(tile_cols),
        .addr_read_input(addr_read_input),
        .read_en_input(read_en_input),
        .data_valid(data_valid),
        .data_read(data_read),
        .pe_data(pe_data),
        .pe_valid(pe_valid),
        .pe_last(pe_last),
        .busy(busy),
        .done(done),
        .aborted(aborted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [10:0] b;
        logic [10:0] s;
        logic [5:0]  nr;
        logic [5:0]  nc;
        int lo;
        int hi;
        int hold;
        int ab_at;
        int e_reads;
        int e_pe;
        int e_last;
        int e_ab;
        int e_dlat;
        int e_pre;
    } vec_t;

    vec_t vecs[9];
    int   n_chk = 0;
    int   n_fail = 0;

    int st_reads, st_pe, st_last, st_ab, st_dlat, st_maxinf, st_pre;
    int st_addrs[$];

    task automatic chk(input string nm, input int act, input int exp_v);
        n_chk++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     nm, act, exp_v, $time);
        end
    endtask

    task automatic run_tile(input vec_t v, input bit rnd_start);
        int total, issued, returned, infl, ph, cyc, due, last_due, eaddr;
        bit e_iss, e_pv, e_pl, e_done, m_busy, m_ab, ab, dv, dec;
        bit got_done, seen_pe;
        logic [15:0] e_pd;
        int due_q[$];
        total = int'(v.nr) * int'(v.nc);
        issued = 0;
        returned = 0;
        infl = 0;
        cyc = 0;
        last_due = -1;
        eaddr = 0;
        e_pd = '0;
        m_ab = 0;
        got_done = 0;
        seen_pe = 0;
        st_reads = 0;
        st_pe = 0;
        st_last = 0;
        st_ab = 0;
        st_dlat = -1;
        st_maxinf = 0;
        st_pre = 0;
        st_addrs.delete();
        @(negedge clk);
        base_addr = v.b;
        row_stride = v.s;
        tile_rows = v.nr;
        tile_cols = v.nc;
        start = 1'b1;
        abort = 1'b0;
        data_valid = 1'b0;
        e_iss = 0;
        e_pv = 0;
        e_pl = 0;
        e_done = 0;
        m_busy = 1;
        ph = (total == 0) ? P_FIN : P_ISS;
        while (!got_done && cyc < 600) begin
            @(negedge clk);
            chk("read_en", read_en_input, e_iss);
            if (read_en_input) begin
                chk("addr", addr_read_input, eaddr);
                st_reads++;
                st_addrs.push_back(int'(addr_read_input));
                due = cyc + $urandom_range(v.hi, v.lo);
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                due_q.push_back(due);
            end
            chk("pe_valid", pe_valid, e_pv);
            if (pe_valid) begin
                if (!seen_pe) st_pre = st_reads - (read_en_input ? 1 : 0);
                seen_pe = 1;
                chk("pe_data", pe_data, e_pd);
                st_pe++;
            end
            chk("pe_last", pe_last, e_pl);
            if (pe_last) st_last++;
            chk("busy", busy, m_busy);
            chk("done", done, e_done);
            chk("aborted", aborted, e_done && m_ab);
            if (done) begin
                got_done = 1;
                st_ab = aborted;
                st_dlat = cyc;
                start = 1'b0;
                abort = 1'b0;
                data_valid = 1'b0;
            end else begin
                start = rnd_start ? 1'($urandom_range(0, 1)) : 1'b0;
                dv = due_q.size() > 0 && due_q[0] <= cyc + 1 && cyc + 1 >= v.hold;
                if (dv) void'(due_q.pop_front());
                data_valid = dv;
                data_read = 16'($urandom);
                ab = v.ab_at >= 0 && issued >= v.ab_at;
                abort = ab;
                e_iss = ph == P_ISS && !ab && infl < MAX && issued < total;
                if (e_iss) begin
                    eaddr = (int'(v.b) + (issued / int'(v.nc)) * int'(v.s)
                             + issued % int'(v.nc)) & 'h7FF;
                end
                e_pv = dv && m_busy;
                e_pd = data_read;
                e_pl = e_pv && (returned == total - 1);
                if (e_pv) returned++;
                e_done = (ph == P_FIN);
                dec = dv && infl > 0;
                infl = infl + (e_iss ? 1 : 0) - (dec ? 1 : 0);
                if (infl > st_maxinf) st_maxinf = infl;
                if (e_iss) issued++;
                case (ph)
                    P_ISS: begin
                        if (ab) begin
                            ph = P_DRN;
                            m_ab = 1;
                        end else if (e_iss && issued == total) begin
                            ph = P_DRN;
                        end
                    end
                    P_DRN: if (infl == 0) ph = P_FIN;
                    P_FIN: begin
                        ph = P_IDLE;
                        m_busy = 0;
                    end
                    default: ;
                endcase
                cyc++;
            end
        end
        if (!got_done) begin
            chk("done_timeout", 0, 1);
            start = 1'b0;
            abort = 1'b0;
            data_valid = 1'b0;
        end
    endtask

    initial begin
        int exp_wrap[6];
        vec_t rv;
        int tot, e_reads, e_ab;
        exp_wrap = '{'h7FE, 'h7FF, 'h000, 'h000, 'h001, 'h002};
        vecs[0] = '{11'h010, 11'h020, 6'd2, 6'd3, 2, 2, 0, -1, 6, 6, 1, 0, 9, -1};
        vecs[1] = '{11'h000, 11'h000, 6'd1, 6'd8, 1, 1, 11, -1, 8, 8, 1, 0, -1, 4};
        vecs[2] = '{11'h7FE, 11'h002, 6'd2, 6'd3, 1, 1, 0, -1, 6, 6, 1, 0, -1, -1};
        vecs[3] = '{11'h100, 11'h010, 6'd0, 6'd5, 1, 1, 0, -1, 0, 0, 0, 0, 1, -1};
        vecs[4] = '{11'h100, 11'h010, 6'd3, 6'd0, 1, 1, 0, -1, 0, 0, 0, 0, 1, -1};
        vecs[5] = '{11'h000, 11'h010, 6'd4, 6'd4, 3, 3, 0, 5, 5, 5, 0, 1, 9, -1};
        vecs[6] = '{11'h3FF, 11'h7FF, 6'd1, 6'd1, 1, 1, 0, -1, 1, 1, 1, 0, 3, -1};
        vecs[7] = '{11'h055, 11'h013, 6'd4, 6'd4, 1, 1, 0, 0, 0, 0, 0, 1, 3, -1};
        vecs[8] = '{11'h200, 11'h040, 6'd3, 6'd4, 1, 4, 0, -1, 12, 12, 1, 0, -1, -1};

        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        base_addr = '0;
        row_stride = '0;
        tile_rows = '0;
        tile_cols = '0;
        data_valid = 1'b0;
        data_read = '0;
        repeat (3) @(negedge clk);
        chk("rst_read_en", read_en_input, 0);
        chk("rst_addr", addr_read_input, 0);
        chk("rst_pe_valid", pe_valid, 0);
        chk("rst_pe_last", pe_last, 0);
        chk("rst_pe_data", pe_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_aborted", aborted, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_read_en", read_en_input, 0);

        data_valid = 1'b1;
        data_read = 16'hBEEF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stray_pe_valid", pe_valid, 0);
            chk("stray_busy", busy, 0);
        end
        data_valid = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run_tile(vecs[i], 1'b0);
            chk("vec_reads", st_reads, vecs[i].e_reads);
            chk("vec_pe", st_pe, vecs[i].e_pe);
            chk("vec_last", st_last, vecs[i].e_last);
            chk("vec_aborted", st_ab, vecs[i].e_ab);
            chk("vec_maxinf_ok", int'(st_maxinf <= MAX), 1);
            if (vecs[i].e_dlat >= 0) chk("vec_done_lat", st_dlat, vecs[i].e_dlat);
            if (vecs[i].e_pre >= 0) chk("vec_pre_ret_reads", st_pre, vecs[i].e_pre);
            if (vecs[i].b == 11'h7FE) begin
                chk("wrap_count", st_addrs.size(), 6);
                for (int k = 0; k < st_addrs.size() && k < 6; k++) begin
                    chk("wrap_addr", st_addrs[k], exp_wrap[k]);
                end
            end
        end

        @(negedge clk);
        base_addr = 11'h020;
        row_stride = 11'h008;
        tile_rows = 6'd3;
        tile_cols = 6'd4;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("mid_read_en1", read_en_input, 1);
        chk("mid_addr1", addr_read_input, 'h020);
        @(negedge clk);
        chk("mid_read_en2", read_en_input, 1);
        chk("mid_addr2", addr_read_input, 'h021);
        #2 rst_n = 1'b0;
        #1;
        chk("async_read_en", read_en_input, 0);
        chk("async_addr", addr_read_input, 0);
        chk("async_busy", busy, 0);
        chk("async_pe_valid", pe_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        data_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("late_pe_valid", pe_valid, 0);
            chk("late_read_en", read_en_input, 0);
            chk("late_busy", busy, 0);
        end
        data_valid = 1'b0;
        rv = '{11'h040, 11'h010, 6'd2, 6'd2, 1, 2, 0, -1, 4, 4, 1, 0, -1, -1};
        run_tile(rv, 1'b0);
        chk("post_rst_reads", st_reads, 4);
        chk("post_rst_pe", st_pe, 4);
        chk("post_rst_last", st_last, 1);

        for (int t = 0; t < 40; t++) begin
            rv.b = 11'($urandom);
            rv.s = 11'($urandom);
            rv.nr = 6'($urandom_range(0, 4));
            rv.nc = 6'($urandom_range(0, 5));
            rv.lo = $urandom_range(1, 3);
            rv.hi = rv.lo + $urandom_range(0, 4);
            rv.hold = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 12) : 0;
            tot = int'(rv.nr) * int'(rv.nc);
            rv.ab_at = ($urandom_range(0, 2) == 0) ? $urandom_range(0, tot) : -1;
            e_ab = (rv.ab_at >= 0 && rv.ab_at < tot) ? 1 : 0;
            e_reads = e_ab ? rv.ab_at : tot;
            run_tile(rv, 1'b1);
            chk("rnd_reads", st_reads, e_reads);
            chk("rnd_pe", st_pe, e_reads);
            chk("rnd_last", st_last, (tot > 0 && !e_ab) ? 1 : 0);
            chk("rnd_aborted", st_ab, e_ab);
            chk("rnd_maxinf_ok", int'(st_maxinf <= MAX), 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
